// File: rtl/audio_spi_arbiter.sv
// audio_spi_arbiter: two-requester round-robin arbiter driving one 16-bit codec SPI register frame per grant
module audio_spi_arbiter #(
  parameter int CLK_DIV   = 63,
  parameter int GAP_TICKS = 4
) (
  input  logic       iCLK_50,
  input  logic       iRESET,
  input  logic       iREQ0,
  input  logic       iWR0,
  input  logic [6:0] iADDR0,
  input  logic [7:0] iWDATA0,
  output logic       oACK0,
  input  logic       iREQ1,
  input  logic       iWR1,
  input  logic [6:0] iADDR1,
  input  logic [7:0] iWDATA1,
  output logic       oACK1,
  output logic [7:0] oRDATA,
  output logic       oBUSY,
  output logic       oGNT,
  output logic       oCS_n,
  output logic       oSCLK,
  output logic       oDIN,
  input  logic       iDOUT
);
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;
  state_t      state;
  logic [15:0] div;
  logic [14:0] tx;
  logic [7:0]  rx;
  logic [4:0]  cnt;
  logic [7:0]  gap;
  logic        last;
  logic        tick;
  logic        sel;
  logic [15:0] frame;
  // requester 1 wins when alone or when requester 0 was served last; reads send 0xFF as filler
  always_comb begin
    tick  = div == 16'(CLK_DIV - 1);
    sel   = (iREQ0 & iREQ1) ? ~last : iREQ1;
    frame = sel ? {iADDR1, ~iWR1, iWR1 ? iWDATA1 : 8'hFF}
                : {iADDR0, ~iWR0, iWR0 ? iWDATA0 : 8'hFF};
    oBUSY = state != IDLE;
  end
  // frame sequencer: grant, 16 SCLK periods (drive on fall, sample on rise), hold, inter-frame gap
  always_ff @(posedge iCLK_50) begin
    if (iRESET) begin
      state  <= IDLE;
      div    <= '0;
      tx     <= '0;
      rx     <= '0;
      cnt    <= '0;
      gap    <= '0;
      last   <= 1'b1;
      oCS_n  <= 1'b1;
      oSCLK  <= 1'b1;
      oDIN   <= 1'b0;
      oACK0  <= 1'b0;
      oACK1  <= 1'b0;
      oRDATA <= '0;
      oGNT   <= 1'b0;
    end else begin
      oACK0 <= 1'b0;
      oACK1 <= 1'b0;
      if (state != IDLE) div <= tick ? '0 : div + 16'd1;
      case (state)
        IDLE: if (iREQ0 | iREQ1) begin
          tx    <= frame[14:0];
          oDIN  <= frame[15];
          oGNT  <= sel;
          last  <= sel;
          oCS_n <= 1'b0;
          cnt   <= '0;
          div   <= '0;
          state <= SETUP;
        end
        SETUP: if (tick) begin
          oSCLK <= 1'b0;
          state <= LOW;
        end
        LOW: if (tick) begin
          oSCLK <= 1'b1;
          rx    <= {rx[6:0], iDOUT};
          cnt   <= cnt + 5'd1;
          state <= HIGH;
        end
        HIGH: if (tick) begin
          if (cnt == 5'd16) state <= HOLD;
          else begin
            oSCLK <= 1'b0;
            oDIN  <= tx[14];
            tx    <= {tx[13:0], 1'b0};
            state <= LOW;
          end
        end
        HOLD: if (tick) begin
          oCS_n  <= 1'b1;
          oACK0  <= ~oGNT;
          oACK1  <= oGNT;
          oRDATA <= rx;
          gap    <= '0;
          state  <= GAP;
        end
        GAP: if (tick) begin
          gap <= gap + 8'd1;
          if (gap == 8'(GAP_TICKS - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_spi_arbiter.sv
// tb_audio_spi_arbiter: directed scoreboard bench with an SPI codec model for audio_spi_arbiter
module tb_audio_spi_arbiter;
  logic       iCLK_50 = 0, iRESET = 1;
  logic       iREQ0 = 0, iWR0 = 0, iREQ1 = 0, iWR1 = 0;
  logic [6:0] iADDR0 = 0, iADDR1 = 0;
  logic [7:0] iWDATA0 = 0, iWDATA1 = 0;
  logic       oACK0, oACK1, oBUSY, oGNT, oCS_n, oSCLK, oDIN;
  logic [7:0] oRDATA;
  logic       iDOUT = 0;

  audio_spi_arbiter #(.CLK_DIV(2), .GAP_TICKS(2)) dut (
    .iCLK_50(iCLK_50), .iRESET(iRESET),
    .iREQ0(iREQ0), .iWR0(iWR0), .iADDR0(iADDR0), .iWDATA0(iWDATA0), .oACK0(oACK0),
    .iREQ1(iREQ1), .iWR1(iWR1), .iADDR1(iADDR1), .iWDATA1(iWDATA1), .oACK1(oACK1),
    .oRDATA(oRDATA), .oBUSY(oBUSY), .oGNT(oGNT),
    .oCS_n(oCS_n), .oSCLK(oSCLK), .oDIN(oDIN), .iDOUT(iDOUT)
  );

  always #10 iCLK_50 = ~iCLK_50;

  typedef struct packed {logic g; logic [15:0] f; logic [7:0] r;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int nbits = 0, cs_low = 0, cs_high = 0, ack_cnt = 0, fall_cnt = 0;
  logic [15:0] frame_obs = 0;
  logic [7:0] reply = 0;
  logic prev_cs = 1, prev_sclk = 1, p_ack = 0, gap_valid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic g, input logic [15:0] f, input logic [7:0] r);
    q.push_back(exp_t'({g, f, r}));
  endfunction

  // codec model and frame monitor: captures oDIN on SCLK rises, drives the reply, checks each ack
  always @(negedge iCLK_50) begin
    exp_t e;
    logic [15:0] r16;
    r16 = {8'h00, reply};
    if (iRESET) gap_valid = 0;
    if (oACK0 | oACK1) begin
      ack_cnt++;
      chk("ack_excl", 32'(oACK0 & oACK1), 0);
      chk("ack_single", 32'(p_ack), 0);
      chk("ack_at_cs_rise", {prev_cs, oCS_n}, 2'b01);
      chk("busy_at_ack", 32'(oBUSY), 1);
      chk("cs_low_len", cs_low, 68);
      chk("bit_count", nbits, 16);
      chk("sb_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("gnt", 32'(oGNT), 32'(e.g));
        chk("ack_idx", 32'(oACK1), 32'(e.g));
        chk("frame", frame_obs, e.f);
        chk("rdata", oRDATA, e.r);
      end
      gap_valid = 1;
    end
    p_ack = oACK0 | oACK1;
    if (oCS_n === 1'b0 && prev_cs) begin
      if (gap_valid) chk("gap_len", 32'(cs_high >= 5), 1);
      fall_cnt++;
      nbits = 0;
      frame_obs = 0;
      cs_low = 1;
      iDOUT = r16[15];
    end else if (oCS_n === 1'b0) begin
      cs_low++;
      if (!prev_sclk && oSCLK) begin
        frame_obs = {frame_obs[14:0], oDIN};
        nbits++;
        if (nbits < 16) iDOUT = r16[4'(15 - nbits)];
      end
    end
    cs_high = oCS_n ? (prev_cs ? cs_high + 1 : 1) : 0;
    prev_cs = oCS_n;
    prev_sclk = oSCLK;
  end

  task automatic wait_ack(input logic who);
    int n;
    n = 0;
    @(negedge iCLK_50);
    while (!(who ? oACK1 : oACK0) && n < 3000) begin
      @(negedge iCLK_50);
      n++;
    end
    chk("ack_timeout", 32'(n < 3000), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (oBUSY && n < 3000) begin
      @(negedge iCLK_50);
      n++;
    end
    chk("idle_timeout", 32'(n < 3000), 1);
  endtask

  task automatic wait_bits(input int b);
    int n;
    n = 0;
    while (nbits != b && n < 3000) begin
      @(negedge iCLK_50);
      n++;
    end
    chk("bits_timeout", 32'(n < 3000), 1);
  endtask

  initial begin
    int n0, n1, cyc, a0, f0;
    logic re0, re1;
    repeat (2) @(negedge iCLK_50);
    iRESET = 0;
    chk("reset_outs", {oCS_n, oSCLK, oDIN, oACK0, oACK1, oRDATA, oBUSY, oGNT},
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    // single write from requester 0
    reply = 8'h00;
    iWR0 = 1; iADDR0 = 7'h1A; iWDATA0 = 8'h5C;
    push(0, 16'h345C, 8'h00);
    iREQ0 = 1;
    wait_ack(0);
    iREQ0 = 0;
    wait_idle();
    // single read from requester 1
    reply = 8'hA5;
    iWR1 = 0; iADDR1 = 7'h20;
    push(1, 16'h41FF, 8'hA5);
    iREQ1 = 1;
    wait_ack(1);
    iREQ1 = 0;
    wait_idle();
    // contention from reset: both held, alternating grants
    reply = 8'h3C;
    iWR0 = 1; iADDR0 = 7'h11; iWDATA0 = 8'h22;
    iWR1 = 0; iADDR1 = 7'h05;
    iREQ0 = 1; iREQ1 = 1; iRESET = 1;
    push(0, 16'h2222, 8'h3C);
    push(1, 16'h0BFF, 8'h3C);
    push(0, 16'h6644, 8'h3C);
    push(1, 16'hFE81, 8'h3C);
    @(negedge iCLK_50);
    iRESET = 0;
    n0 = 0; n1 = 0; cyc = 0; re0 = 0; re1 = 0;
    while ((n0 < 2 || n1 < 2) && cyc < 5000) begin
      @(negedge iCLK_50);
      cyc++;
      if (re0) begin iREQ0 = 1; re0 = 0; end
      if (re1) begin iREQ1 = 1; re1 = 0; end
      if (oACK0) begin
        n0++; iREQ0 = 0;
        if (n0 < 2) begin iADDR0 = 7'h33; iWDATA0 = 8'h44; re0 = 1; end
      end
      if (oACK1) begin
        n1++; iREQ1 = 0;
        if (n1 < 2) begin iWR1 = 1; iADDR1 = 7'h7F; iWDATA1 = 8'h81; re1 = 1; end
      end
    end
    chk("contention_acks", n0 + n1, 4);
    wait_idle();
    // back-to-back: new transaction presented right after the ack
    reply = 8'h00;
    a0 = ack_cnt; f0 = fall_cnt;
    iWR0 = 1; iADDR0 = 7'h01; iWDATA0 = 8'h02;
    push(0, 16'h0202, 8'h00);
    push(0, 16'h0604, 8'h00);
    iREQ0 = 1;
    wait_ack(0);
    iADDR0 = 7'h03; iWDATA0 = 8'h04;
    wait_ack(0);
    iREQ0 = 0;
    wait_idle();
    chk("b2b_acks", ack_cnt - a0, 2);
    chk("b2b_frames", fall_cnt - f0, 2);
    // reset in the middle of a write
    iWR0 = 1; iADDR0 = 7'h55; iWDATA0 = 8'hAA;
    iREQ0 = 1;
    @(negedge iCLK_50);
    wait_bits(7);
    iRESET = 1; iREQ0 = 0;
    @(negedge iCLK_50);
    iRESET = 0;
    chk("mid_reset", {oCS_n, oSCLK, oBUSY, oACK0, oACK1}, 5'b11000);
    repeat (4) @(negedge iCLK_50);
    iADDR0 = 7'h2B; iWDATA0 = 8'h9D;
    push(0, 16'h569D, 8'h00);
    iREQ0 = 1;
    wait_ack(0);
    iREQ0 = 0;
    wait_idle();
    // fields changed after grant must not affect the frame
    iWR1 = 1; iADDR1 = 7'h0C; iWDATA1 = 8'h3E;
    push(1, 16'h183E, 8'h00);
    iREQ1 = 1;
    @(negedge iCLK_50);
    wait_bits(5);
    iWR1 = 0; iADDR1 = 7'h7F; iWDATA1 = 8'hFF;
    wait_ack(1);
    iREQ1 = 0;
    wait_idle();
    repeat (4) @(negedge iCLK_50);
    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
